piso_shift: RTL and testbench
=============================

PISO_SHIFT -- requirements
Module: piso_shift

Interface
REQ-001 Parameter WIDTH, default 4, number of data bits per frame (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = shift out bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 load_valid  input  1  parallel word offered on din.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 din  input  WIDTH  parallel data word.
REQ-008 dout  output  1  serial data bit.
REQ-009 dout_valid  output  1  dout carries a frame bit this cycle.
REQ-010 done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-011 A word SHALL be accepted on a rising clk edge where load_valid and load_ready are both 1; din is captured into the shift register at that edge.
REQ-012 FSM states SHALL be IDLE and SHIFT, plus PAR when PARITY_EN is defined.
REQ-013 IDLE -> SHIFT on acceptance.
REQ-014 SHIFT -> IDLE after the last data bit when PARITY_EN is undefined and no new word is accepted.
REQ-015 SHIFT -> PAR after the last data bit when PARITY_EN is defined.
REQ-016 PAR -> IDLE after one cycle, or -> SHIFT on acceptance.
REQ-017 Latency: the first bit SHALL appear on dout with dout_valid=1 in the cycle immediately after the accepting edge.
REQ-018 Bits SHALL follow on consecutive cycles, exactly one per clk, with no gaps inside a frame.
REQ-019 dout_valid SHALL be 1 for exactly WIDTH cycles per frame, or WIDTH+1 with PARITY_EN.
REQ-020 dout SHALL be 0 whenever dout_valid=0.
REQ-021 done SHALL be 1 only in the cycle carrying the final bit of the frame (the last data bit, or the parity bit with PARITY_EN).
REQ-022 load_ready SHALL be 1 in IDLE and in the final-bit cycle, and 0 otherwise.
REQ-023 An acceptance in the final-bit cycle SHALL start the next frame on the following cycle with no idle gap (back-to-back frames).
REQ-024 load_valid while load_ready=0 SHALL be ignored; the frame in progress is not disturbed and din is not captured.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide, count 0..WIDTH-1 in SHIFT, and wrap to 0 on frame end or reload.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL set state=IDLE, shift register=0, counter=0, dout=0, dout_valid=0, done=0 and load_ready=0.
REQ-027 load_ready SHALL go to 1 at the first rising clk edge after rst deasserts.
REQ-028 Reset asserted mid-frame SHALL abort and discard the frame; no further bits of it are emitted after reset is released.
REQ-029 load_valid sampled while rst=1 SHALL be ignored.

Configuration
REQ-030 Macro PISO_SHIFT_PARITY_EN SHALL control an even-parity bit appended to each frame.
REQ-031 With PISO_SHIFT_PARITY_EN defined, the parity bit SHALL equal the XOR of the accepted din, be emitted in state PAR immediately after the last data bit with dout_valid=1, and carry done=1.
REQ-032 With PISO_SHIFT_PARITY_EN undefined, state PAR and all parity logic SHALL be absent, and frames are WIDTH bits long.

Structure
REQ-033 Package piso_shift_pkg SHALL hold the FSM state encoding (IDLE, SHIFT, PAR) and the counter-width function.
REQ-034 The bit counter SHALL be a sub-module piso_bit_cnt with ports clk, rst, clr, en, cnt and last.
REQ-035 Shift register, FSM and output registers SHALL reside in piso_shift; all outputs SHALL be registered.

Verification
REQ-036 WIDTH=4, MSB_FIRST=1: load 4'b1011 -> dout=1,0,1,1 on cycles 1-4 after acceptance; dout_valid=1 on those cycles; done=1 on cycle 4 only.
REQ-037 MSB_FIRST=0: load 4'b1011 -> dout=1,1,0,1; then dout_valid=0 and load_ready=1 on cycle 5.
REQ-038 Back-to-back: hold load_valid=1 with 4'b1100 then 4'b0011 -> 8 contiguous valid bits 1,1,0,0,0,0,1,1 with no gap, and done on cycles 4 and 8.
REQ-039 Assert rst during the cycle-2 bit of 4'b1111 -> dout=0, dout_valid=0 and load_ready=0 immediately; after release the next accepted word 4'b0001 is emitted cleanly.
REQ-040 PISO_SHIFT_PARITY_EN defined: load 4'b0111 -> 0,1,1,1 then parity bit 1; done on cycle 5; load_ready=0 on cycles 1-4.
REQ-041 Pulse load_valid mid-frame while load_ready=0 -> ignored; output stream is unchanged and no extra frame is emitted.

Source files
------------

// File: rtl/piso_shift_pkg.sv
// FSM state encoding and counter sizing shared by piso_shift and piso_bit_cnt.
// PAR exists only when PISO_SHIFT_PARITY_EN is defined.
package piso_shift_pkg;

`ifdef PISO_SHIFT_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  // Wide enough to hold 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter: clears on clr, advances on en, flags the terminal count MAX.
// Zero latency on last; clr has priority over en.
module piso_bit_cnt #(
  parameter int MAX = 3,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(MAX));

endmodule

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter; optional even parity bit under PISO_SHIFT_PARITY_EN.
// First bit one cycle after accept; load_ready only in idle or final-bit cycle, so frames chain with no gap.
module piso_shift
  import piso_shift_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             dout_valid,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;
`ifdef PISO_SHIFT_PARITY_EN
  logic             par;
`else
  logic             penult;
`endif

  function automatic logic head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  assign accept  = load_valid & load_ready;
  assign sr_next = (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
  // Counter only advances between data bits; every other cycle parks it at 0.
  assign cnt_en  = (state == SHIFT) & ~last;
  assign cnt_clr = accept | ~cnt_en;
`ifndef PISO_SHIFT_PARITY_EN
  assign penult  = (cnt == CW'(WIDTH - 2));
`endif

  piso_bit_cnt #(
    .MAX (WIDTH - 1),
    .CW  (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
`ifdef PISO_SHIFT_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
      // Acceptance is only possible in IDLE or the final-bit cycle, so it always starts a frame.
      if (accept) begin
        state      <= SHIFT;
        sr         <= din;
        dout       <= head(din);
        dout_valid <= 1'b1;
`ifdef PISO_SHIFT_PARITY_EN
        par        <= ^din;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (!last) begin
              sr         <= sr_next;
              dout       <= head(sr_next);
              dout_valid <= 1'b1;
`ifndef PISO_SHIFT_PARITY_EN
              done       <= penult;
              load_ready <= penult;
`endif
            end else begin
`ifdef PISO_SHIFT_PARITY_EN
              state      <= PAR;
              dout       <= par;
              dout_valid <= 1'b1;
              done       <= 1'b1;
              load_ready <= 1'b1;
`else
              state      <= IDLE;
              load_ready <= 1'b1;
`endif
            end
          end
          default: begin
            state      <= IDLE;
            load_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_shift.sv
// Directed frames then random traffic, checked against a per-frame bit-queue model.
// Two instances (MSB_FIRST=1 and 0) share one stimulus stream.
module tb_piso_shift;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [3:0] din;
  logic       rdy_m, dout_m, vld_m, done_m;
  logic       rdy_l, dout_l, vld_l, done_l;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Bits still to appear on dout; element 0 is the bit shown this cycle.
  logic q_m[$];
  logic q_l[$];
  bit   rdy_en;
  logic [15:0] hist_m, hist_l, hist_d, hist_r;

  piso_shift #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m),
    .din(din), .dout(dout_m), .dout_valid(vld_m), .done(done_m)
  );

  piso_shift #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l),
    .din(din), .dout(dout_l), .dout_valid(vld_l), .done(done_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic exp_ready();
    return rdy_en && (q_m.size() <= 1);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic em, el;
    em = (q_m.size() > 0) ? q_m[0] : 1'b0;
    el = (q_l.size() > 0) ? q_l[0] : 1'b0;
    chk({tag, " m.dout"}, dout_m, em);
    chk({tag, " m.vld"},  vld_m,  q_m.size() > 0);
    chk({tag, " m.done"}, done_m, q_m.size() == 1);
    chk({tag, " m.rdy"},  rdy_m,  exp_ready());
    chk({tag, " l.dout"}, dout_l, el);
    chk({tag, " l.vld"},  vld_l,  q_l.size() > 0);
    chk({tag, " l.done"}, done_l, q_l.size() == 1);
    chk({tag, " l.rdy"},  rdy_l,  exp_ready());
    hist_m = {hist_m[14:0], dout_m};
    hist_l = {hist_l[14:0], dout_l};
    hist_d = {hist_d[14:0], done_m};
    hist_r = {hist_r[14:0], rdy_m};
  endtask

  task automatic model_edge(input logic lv, input logic [3:0] d);
    logic acc;
    acc = lv && exp_ready();
    if (q_m.size() > 0) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (acc) begin
      for (int i = 3; i >= 0; i--) q_m.push_back(d[i]);
      for (int i = 0; i < 4; i++)  q_l.push_back(d[i]);
`ifdef PISO_SHIFT_PARITY_EN
      q_m.push_back(^d);
      q_l.push_back(^d);
`endif
    end
    rdy_en = 1'b1;
  endtask

  task automatic cycle(input logic lv, input logic [3:0] d);
    load_valid = lv;
    din        = d;
    @(posedge clk);
    model_edge(lv, d);
    cyc++;
    @(negedge clk);
    compare_all("run");
  endtask

  // Called just after a negedge; reset spans one rising edge with load_valid high.
  task automatic mid_reset();
    rst        = 1'b1;
    load_valid = 1'b1;
    din        = 4'($urandom_range(0, 15));
    #1;
    q_m.delete();
    q_l.delete();
    rdy_en = 1'b0;
    compare_all("rst_now");
    @(posedge clk);
    @(negedge clk);
    compare_all("rst_hold");
    rst        = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b1;
    din        = 4'hF;
    rdy_en     = 1'b0;
    hist_m = '0; hist_l = '0; hist_d = '0; hist_r = '0;

    #2;
    compare_all("por");
    @(posedge clk);
    @(negedge clk);
    compare_all("por_hold");
    rst        = 1'b0;
    load_valid = 1'b0;

    cycle(1'b0, 4'h0);
    chk("first_rdy", rdy_m, 1'b1);

`ifdef PISO_SHIFT_PARITY_EN
    cycle(1'b1, 4'h7);
    repeat (4) cycle(1'b0, 4'h0);
    chkv("par_bits", hist_m & 16'h001F, 16'h000F);
    chkv("par_done", hist_d & 16'h001F, 16'h0001);
    chkv("par_rdy",  hist_r & 16'h001F, 16'h0001);
`else
    // Single frame 1011 in both bit orders.
    cycle(1'b1, 4'hB);
    repeat (3) cycle(1'b0, 4'h0);
    chkv("msb_bits", hist_m & 16'h000F, 16'h000B);
    chkv("lsb_bits", hist_l & 16'h000F, 16'h000D);
    chkv("msb_done", hist_d & 16'h000F, 16'h0001);
    cycle(1'b0, 4'h0);
    chk("idle_vld", vld_l, 1'b0);
    chk("idle_rdy", rdy_l, 1'b1);

    // Back-to-back with load_valid held through the non-ready cycles.
    cycle(1'b1, 4'hC);
    repeat (4) cycle(1'b1, 4'h3);
    repeat (3) cycle(1'b0, 4'h0);
    chkv("b2b_bits", hist_m & 16'h00FF, 16'h00C3);
    chkv("b2b_done", hist_d & 16'h00FF, 16'h0011);
    cycle(1'b0, 4'h0);
    chk("b2b_end", vld_m, 1'b0);

    // Reset during the second bit of 1111, then a clean 0001 frame.
    cycle(1'b1, 4'hF);
    cycle(1'b0, 4'h0);
    mid_reset();
    chk("rst_vld", vld_m, 1'b0);
    cycle(1'b0, 4'h0);
    cycle(1'b1, 4'h1);
    repeat (3) cycle(1'b0, 4'h0);
    chkv("post_rst_m", hist_m & 16'h000F, 16'h0001);
    chkv("post_rst_l", hist_l & 16'h000F, 16'h0008);
`endif

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 79) == 0) mid_reset();
      else cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
    end
    repeat (6) cycle(1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
